// File: rtl/pattern_encoder.sv
// pattern_encoder
// ---------------------------------------------------------------------------
// Serialises one channel's configuration into a fixed byte packet and hands
// it to a byte-level UART transmitter, one byte per TX handshake.
//
// Packet layout (byte index : content)
//   0                       : {sel_out[3:0], 1'b0, mode, stop, start}
//   1 .. DATA_BIT/8         : output pattern, most significant byte first
//   next DATA_BIT/8 bytes   : frequency pattern, most significant byte first
//   PACK_NUM (optional)     : XOR of all preceding bytes
//
// Build option
//   PATTERN_ENCODER_CHECKSUM_EN : when defined, a checksum byte is appended
//                                 and the packet becomes PACK_NUM+1 bytes.
//
// Parameters
//   DATA_BIT  pattern width, multiple of 8
//   PACK_NUM  bytes per packet, 1 + 2*DATA_BIT/8
//
// Ports
//   clk               in   system clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   i_start_tick      in   one-cycle request, latches every i_* field
//   i_output_pattern  in   level pattern to encode
//   i_freq_pattern    in   per-bit frequency pattern to encode
//   i_sel_out         in   target channel index
//   i_start/i_stop/i_mode in control flags
//   i_tx_done_tick    in   TX finished the current byte
//   o_tx_start_tick   out  one-cycle pulse, TX loads o_tx_data
//   o_tx_data         out  byte being sent, stable until the next start pulse
//   o_busy            out  high while a packet is in progress
//   o_done_tick       out  one-cycle pulse after the last byte completes
// ---------------------------------------------------------------------------
module pattern_encoder #(
  parameter int DATA_BIT = 32,
  parameter int PACK_NUM = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start_tick,
  input  logic [DATA_BIT-1:0] i_output_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [3:0]          i_sel_out,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_mode,
  input  logic                i_tx_done_tick,
  output logic                o_tx_start_tick,
  output logic [7:0]          o_tx_data,
  output logic                o_busy,
  output logic                o_done_tick
);

  localparam int NB = DATA_BIT / 8;
  localparam int CW = $clog2(PACK_NUM + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] PACK_LIMIT = CW'(PACK_NUM);
`ifdef PATTERN_ENCODER_CHECKSUM_EN
  localparam logic [CW-1:0] LAST_IDX = CW'(PACK_NUM);
`else
  localparam logic [CW-1:0] LAST_IDX = CW'(PACK_NUM - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [3:0]          sel_q;
  logic                start_q;
  logic                stop_q;
  logic                mode_q;
  logic [DATA_BIT-1:0] out_q;
  logic [DATA_BIT-1:0] freq_q;
  logic [CW-1:0]       cnt;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                busy;
  logic                done;

  logic [7:0]          pkt_bytes [PACK_NUM];
  logic [CW-1:0]       nxt_idx;
  logic [7:0]          nxt_byte;

`ifdef PATTERN_ENCODER_CHECKSUM_EN
  // XOR fold of every packet byte; a receiver XOR-ing the whole packet
  // including this byte sees zero.
  function automatic logic [7:0] xor_fold(input logic [7:0] b [PACK_NUM]);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < PACK_NUM; k++) begin
      acc = acc ^ b[k];
    end
    return acc;
  endfunction
`endif

  // Packet image assembled from the latched fields, one byte per entry.
  always_comb begin
    for (int k = 0; k < PACK_NUM; k++) begin
      pkt_bytes[k] = 8'h00;
    end
    pkt_bytes[0] = {sel_q, 1'b0, mode_q, stop_q, start_q};
    for (int k = 0; k < NB; k++) begin
      pkt_bytes[1 + k]      = out_q[DATA_BIT-1-8*k -: 8];
      pkt_bytes[1 + NB + k] = freq_q[DATA_BIT-1-8*k -: 8];
    end
  end

  // Byte that follows the one currently on o_tx_data.
  always_comb begin
    nxt_idx = cnt + CNT_ONE;
    if (nxt_idx < PACK_LIMIT) begin
      nxt_byte = pkt_bytes[nxt_idx];
    end else begin
`ifdef PATTERN_ENCODER_CHECKSUM_EN
      nxt_byte = xor_fold(pkt_bytes);
`else
      nxt_byte = 8'h00;
`endif
    end
  end

  // Packet sequencer. Every output is a register updated on the same edge
  // as the state it belongs to, so the first start pulse and o_busy appear
  // in the cycle right after the accepting edge. Byte 0 is built from the
  // inputs directly because the field registers load on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sel_q    <= 4'h0;
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      mode_q   <= 1'b0;
      out_q    <= {DATA_BIT{1'b0}};
      freq_q   <= {DATA_BIT{1'b0}};
      cnt      <= {CW{1'b0}};
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start_tick) begin
            sel_q    <= i_sel_out;
            start_q  <= i_start;
            stop_q   <= i_stop;
            mode_q   <= i_mode;
            out_q    <= i_output_pattern;
            freq_q   <= i_freq_pattern;
            cnt      <= {CW{1'b0}};
            tx_data  <= {i_sel_out, 1'b0, i_mode, i_stop, i_start};
            tx_start <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD;
          end else begin
            busy <= 1'b0;
          end
        end
        S_LOAD: begin
          // An ack arriving together with the start pulse belongs to no
          // byte yet and is dropped here.
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_tx_done_tick) begin
            if (cnt == LAST_IDX) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              cnt      <= nxt_idx;
              tx_data  <= nxt_byte;
              tx_start <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_start_tick = tx_start;
  assign o_tx_data       = tx_data;
  assign o_busy          = busy;
  assign o_done_tick     = done;

endmodule

// File: tb/tb_pattern_encoder.sv
// Directed testbench for pattern_encoder: drives hand-written packets
// through a simple TX acknowledge model and checks the emitted byte stream,
// handshake latencies, o_busy duration and reset behaviour.
module tb_pattern_encoder;

  localparam int DATA_BIT = 32;
  localparam int PACK_NUM = 9;
`ifdef PATTERN_ENCODER_CHECKSUM_EN
  localparam int NBYTES = PACK_NUM + 1;
`else
  localparam int NBYTES = PACK_NUM;
`endif

  logic                clk;
  logic                rst_n;
  logic                i_start_tick;
  logic [DATA_BIT-1:0] i_output_pattern;
  logic [DATA_BIT-1:0] i_freq_pattern;
  logic [3:0]          i_sel_out;
  logic                i_start;
  logic                i_stop;
  logic                i_mode;
  logic                i_tx_done_tick;
  logic                o_tx_start_tick;
  logic [7:0]          o_tx_data;
  logic                o_busy;
  logic                o_done_tick;

  logic model_ack = 1'b0;
  logic inj_ack   = 1'b0;
  assign i_tx_done_tick = model_ack | inj_ack;

  pattern_encoder #(.DATA_BIT(DATA_BIT), .PACK_NUM(PACK_NUM)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start_tick     (i_start_tick),
    .i_output_pattern (i_output_pattern),
    .i_freq_pattern   (i_freq_pattern),
    .i_sel_out        (i_sel_out),
    .i_start          (i_start),
    .i_stop           (i_stop),
    .i_mode           (i_mode),
    .i_tx_done_tick   (i_tx_done_tick),
    .o_tx_start_tick  (o_tx_start_tick),
    .o_tx_data        (o_tx_data),
    .o_busy           (o_busy),
    .o_done_tick      (o_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // TX model knobs
  int ack_min = 1;
  int ack_max = 1;
  bit dup_en  = 1'b0;
  int model_d = 0;

  // Monitor state
  logic [7:0] bytes [$];
  int   cyc          = 0;
  int   busy_cycles  = 0;
  int   done_cnt     = 0;
  int   stab_err     = 0;
  int   lat_err      = 0;
  int   busy_late    = 0;
  int   last_ack_cyc = 0;
  logic prev_busy    = 1'b0;
  logic prev_done    = 1'b0;
  logic [7:0] held   = 8'h00;

  logic [7:0] exp_a [$];
  logic [7:0] exp_c [$];
  int b0, d0, bz0, s0, l0, bl0, n;

  // TX model: acks each byte d cycles after its start pulse; optionally
  // also raises ack in the start cycle itself, which must be ignored.
  always @(negedge clk) begin
    if (rst_n && o_tx_start_tick) begin
      model_d = int'($urandom_range(ack_max, ack_min));
      if (dup_en) model_ack = 1'b1;
      for (int k = 0; k < model_d; k++) begin
        @(posedge clk);
        #1 model_ack = 1'b0;
      end
      model_ack = 1'b1;
      @(posedge clk);
      #1 model_ack = 1'b0;
    end
  end

  // Monitor, sampling mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_busy) busy_cycles = busy_cycles + 1;
    if (o_done_tick) done_cnt = done_cnt + 1;
    if (prev_done && o_busy) busy_late = busy_late + 1;
    if (o_tx_start_tick) begin
      if (prev_busy && (cyc - last_ack_cyc != 1)) lat_err = lat_err + 1;
      bytes.push_back(o_tx_data);
      held = o_tx_data;
    end else if (o_busy && prev_busy && (o_tx_data !== held)) begin
      stab_err = stab_err + 1;
    end
    if (i_tx_done_tick) last_ack_cyc = cyc;
    prev_busy = o_busy;
    prev_done = o_done_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the edge that sampled the request.
  task automatic pulse_req(input logic [3:0] sel, input logic st, input logic sp,
                           input logic md, input logic [31:0] outp, input logic [31:0] fr);
    i_sel_out        = sel;
    i_start          = st;
    i_stop           = sp;
    i_mode           = md;
    i_output_pattern = outp;
    i_freq_pattern   = fr;
    i_start_tick     = 1'b1;
    @(posedge clk);
    #1;
    i_start_tick     = 1'b0;
    i_sel_out        = 4'($urandom);
    i_start          = 1'($urandom);
    i_stop           = 1'($urandom);
    i_mode           = 1'($urandom);
    i_output_pattern = $urandom;
    i_freq_pattern   = $urandom;
  endtask

  task automatic wait_done(input string tag, input int dref, input int budget);
    int k;
    k = 0;
    while (done_cnt == dref && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != dref), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b0  = bytes.size();
    d0  = done_cnt;
    bz0 = busy_cycles;
    s0  = stab_err;
    l0  = lat_err;
    bl0 = busy_late;
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] exp [$], input bit chk_busy);
    chk({tag, "_count"}, 32'(bytes.size() - b0), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++) begin
      if (b0 + i < bytes.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(bytes[b0 + i]), 32'(exp[i]));
      else
        chk($sformatf("%s_byte%0d_missing", tag, i), 32'hFFFF_FFFF, 32'(exp[i]));
    end
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_stable"}, 32'(stab_err - s0), 32'd0);
    chk({tag, "_ack_to_start"}, 32'(lat_err - l0), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy_late - bl0), 32'd0);
    if (chk_busy) chk({tag, "_busy_cycles"}, 32'(busy_cycles - bz0), 32'(2 * NBYTES + 1));
  endtask

  task automatic run_pkt(input string tag, input logic [7:0] exp [$], input logic [3:0] sel,
                         input logic st, input logic sp, input logic md,
                         input logic [31:0] outp, input logic [31:0] fr,
                         input bit chk_busy, input int budget);
    snap();
    pulse_req(sel, st, sp, md, outp, fr);
    chk({tag, "_first_busy"}, 32'(o_busy), 32'd1);
    chk({tag, "_first_start"}, 32'(o_tx_start_tick), 32'd1);
    chk({tag, "_first_data"}, 32'(o_tx_data), 32'(exp[0]));
    wait_done(tag, d0, budget);
    check_pkt(tag, exp, chk_busy);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_a = '{8'h25, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 8'hA5, 8'h0F, 8'h0F};
    exp_c = '{8'h96, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00, 8'hFF, 8'h7E, 8'h81};
`ifdef PATTERN_ENCODER_CHECKSUM_EN
    exp_a.push_back(8'h2D);
    exp_c.push_back(8'h5F);
`endif
    rst_n            = 1'b0;
    i_start_tick     = 1'b0;
    i_output_pattern = 32'h0;
    i_freq_pattern   = 32'h0;
    i_sel_out        = 4'h0;
    i_start          = 1'b0;
    i_stop           = 1'b0;
    i_mode           = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 32'(o_tx_start_tick), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'h00);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done_tick), 32'd0);
    rst_n = 1'b1;

    // Idle for 10 cycles: nothing happens
    snap();
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_start", 32'(bytes.size() - b0), 32'd0);
    chk("idle_busy_cycles", 32'(busy_cycles - bz0), 32'd0);
    chk("idle_done", 32'(done_cnt - d0), 32'd0);

    // Stray ack while idle is ignored
    inj_ack = 1'b1;
    @(posedge clk);
    #1 inj_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_ack_no_start", 32'(bytes.size() - b0), 32'd0);
    chk("idle_ack_busy", 32'(o_busy), 32'd0);

    // Basic packet, ack one cycle after each start
    run_pkt("pktA", exp_a, 4'd2, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'hA5A50F0F, 1'b1, 200);

    // Random ack delays 1..50
    ack_min = 1;
    ack_max = 50;
    run_pkt("pktA_rand", exp_a, 4'd2, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'hA5A50F0F, 1'b0, 2000);

    // Duplicate ack in the start cycle
    ack_min = 2;
    ack_max = 2;
    dup_en  = 1'b1;
    run_pkt("pktA_dup", exp_a, 4'd2, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'hA5A50F0F, 1'b0, 300);
    dup_en  = 1'b0;
    ack_min = 1;
    ack_max = 1;

    // Request mid-packet with different fields is ignored
    snap();
    pulse_req(4'd2, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'hA5A50F0F);
    repeat (6) @(posedge clk);
    #1;
    pulse_req(4'hF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h01020304);
    wait_done("midreq", d0, 200);
    check_pkt("midreq", exp_a, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("midreq_no_second", 32'(bytes.size() - b0), 32'(NBYTES));
    chk("midreq_no_second_done", 32'(done_cnt - d0), 32'd1);
    chk("midreq_idle", 32'(o_busy), 32'd0);

    // Reset after byte 4 aborts the packet
    snap();
    pulse_req(4'd2, 1'b1, 1'b0, 1'b1, 32'h12345678, 32'hA5A50F0F);
    n = 0;
    while (bytes.size() < b0 + 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reached_byte4", 32'(bytes.size() - b0), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_start", 32'(o_tx_start_tick), 32'd0);
    chk("rstmid_data", 32'(o_tx_data), 32'h00);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_done", 32'(o_done_tick), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rstmid_no_more_bytes", 32'(bytes.size() - b0), 32'd5);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);

    // Fresh request after reset uses the new fields from byte 0
    run_pkt("pktC", exp_c, 4'd9, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 32'h00FF7E81, 1'b1, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_encoder.md
# pattern_encoder

Packs one channel's serial-out configuration into a fixed byte packet for a UART transmitter. It captures a 32-bit output pattern, a 32-bit frequency pattern, a channel select and start/stop/mode flags. It then streams PACK_NUM bytes through a byte-level TX handshake. It is the transmit-side counterpart of the packet decoder, used for host read-back and for board-to-board chaining of channel setups.

## Interface
- DATA_BIT, 32: pattern width; must be a multiple of 8.
- PACK_NUM, 9: bytes per packet; must equal 1 + 2*DATA_BIT/8.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_start_tick  in  1  one-cycle request; captures all i_* fields.
- i_output_pattern  in  DATA_BIT  level pattern to encode.
- i_freq_pattern  in  DATA_BIT  per-bit frequency pattern to encode.
- i_sel_out  in  4  target channel index.
- i_start, i_stop, i_mode  in  1 each  control flags.
- i_tx_done_tick  in  1  UART TX finished the current byte.
- o_tx_start_tick  out  1  one-cycle pulse; the TX loads o_tx_data.
- o_tx_data  out  8  byte being sent; held stable until the next o_tx_start_tick.
- o_busy  out  1  high while a packet is in progress.
- o_done_tick  out  1  one-cycle pulse after the last byte completes.

## Operation
- Byte 0 (control): [7:4]=sel_out, [3]=0, [2]=mode, [1]=stop, [0]=start.
- Bytes 1..DATA_BIT/8: output pattern, MSB byte first.
- Next DATA_BIT/8 bytes: frequency pattern, MSB byte first.
- All fields are latched into internal registers on an accepted i_start_tick. After that, inputs may change freely.
- FSM states:
  - S_IDLE: i_start_tick latches the fields, clears the byte counter and goes to S_LOAD.
  - S_LOAD: drives o_tx_data from the packet at the counter index, pulses o_tx_start_tick, then goes to S_WAIT.
  - S_WAIT: on i_tx_done_tick, if the counter is at the last byte go to S_DONE; otherwise increment the counter and go to S_LOAD.
  - S_DONE: pulses o_done_tick, then returns to S_IDLE.
- o_busy = (state != S_IDLE).
- i_start_tick outside S_IDLE is ignored; it is neither queued nor able to corrupt the latched fields.
- i_tx_done_tick outside S_WAIT is ignored.
- Byte counter width is clog2(PACK_NUM+1). It never wraps within a packet and is cleared on every accept.

## Timing
- Reset values: o_tx_start_tick=0, o_tx_data=0x00, o_busy=0, o_done_tick=0. State is S_IDLE, latched fields are 0 and the counter is 0.
- Reset asserted mid-packet aborts immediately. No further o_tx_start_tick and no o_done_tick are produced.
- Outputs are registered or decoded from state only; none depends combinationally on any i_* input.
- i_start_tick sampled at edge N: o_busy high and first o_tx_start_tick both occur in cycle N+1.
- i_tx_done_tick sampled at edge M (not the last byte): next o_tx_start_tick occurs in cycle M+1.
- Last byte's i_tx_done_tick at M: o_done_tick in cycle M+1, o_busy low from cycle M+2.
- Earliest next accept is an i_start_tick in cycle M+2.
- Minimum packet duration is 2*PACK_NUM+1 cycles when i_tx_done_tick arrives the cycle after each start.

## Configuration
- PATTERN_ENCODER_CHECKSUM_EN defined: one extra byte is appended after the frequency pattern. It is the XOR of all PACK_NUM preceding bytes, so the packet is PACK_NUM+1 bytes and o_done_tick follows that byte's i_tx_done_tick.
- Macro undefined: exactly PACK_NUM bytes are sent and no checksum logic is present.

## Test plan
- Reset, then idle 10 cycles: all outputs stay 0 and no o_tx_start_tick occurs.
- Encode sel=2, start=1, stop=0, mode=1, output=0x12345678, freq=0xA5A50F0F, with the TX model acking 1 cycle after each start.
  - Expected bytes: 25 12 34 56 78 A5 A5 0F 0F.
  - One o_done_tick; o_busy is high for exactly 19 cycles.
  - With PATTERN_ENCODER_CHECKSUM_EN defined, a tenth byte 0x2D follows.
- Same packet with the TX model acking after random 1–50 cycles: byte sequence is unchanged and o_tx_data is stable between starts.
- i_start_tick pulsed mid-packet with different fields: the packet in flight is unchanged and no second packet is sent.
- i_tx_done_tick pulsed while in S_IDLE, and a duplicate ack in the same cycle as o_tx_start_tick: both are ignored and no byte is skipped.
- rst_n dropped after byte 4: outputs return to reset values at once. A fresh request afterward sends byte 0 first with the new fields.
